// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Results are computed at accept time and held pending until the fixed-latency commit.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [1:0]  MDU_Op,
  input  logic        HI_En,
  input  logic        LO_En,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  input  logic        Out_Sel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_Out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;

  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_pend_hi;
  logic [31:0]   r_pend_lo;
  logic          r_pend_skip;

  logic          w_is_div;
  logic          w_signed;
  logic [63:0]   w_a_ext;
  logic [63:0]   w_b_ext;
  logic [63:0]   w_prod;
  logic          w_a_neg;
  logic          w_b_neg;
  logic [31:0]   w_a_mag;
  logic [31:0]   w_b_mag;
  logic [31:0]   w_uquot;
  logic [31:0]   w_urem;
  logic [31:0]   w_quot;
  logic [31:0]   w_rem;
  logic [31:0]   w_res_hi;
  logic [31:0]   w_res_lo;
  logic          w_div_zero;

  logic          w_accept;
  logic          w_move_ok;
  logic          w_commit;

  // Op[1] selects divide, Op[0] selects unsigned.
  assign w_is_div = MDU_Op[1];
  assign w_signed = ~MDU_Op[0];

  // Sign-extending only for signed ops lets one 64-bit multiplier serve mult and multu.
  assign w_a_ext = {{32{A[31] & w_signed}}, A};
  assign w_b_ext = {{32{B[31] & w_signed}}, B};
  assign w_prod  = w_a_ext * w_b_ext;

  // Signed divide goes through magnitudes; 0x80000000 / -1 falls out as LO=0x80000000, HI=0.
  assign w_a_neg  = w_signed & A[31];
  assign w_b_neg  = w_signed & B[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - A) : A;
  assign w_b_mag  = w_b_neg ? (32'd0 - B) : B;
  assign w_uquot  = w_a_mag / w_b_mag;
  assign w_urem   = w_a_mag % w_b_mag;
  assign w_quot   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uquot) : w_uquot;
  assign w_rem    = w_a_neg ? (32'd0 - w_urem) : w_urem;

  assign w_res_hi   = w_is_div ? w_rem  : w_prod[63:32];
  assign w_res_lo   = w_is_div ? w_quot : w_prod[31:0];
  assign w_div_zero = w_is_div && (B == 32'd0);

  assign w_accept  = (r_state == S_IDLE) && Start && !Req;
  assign w_move_ok = (r_state == S_IDLE) && !Start && !Req;
  assign w_commit  = (r_state == S_RUN) && (r_count == CW'(1));

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_RUN;
          w_count_next = w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
      end
      S_RUN: begin
        w_count_next = r_count - CW'(1);
        if (r_count == CW'(1)) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_count_next = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_hi   <= '0;
      r_pend_lo   <= '0;
      r_pend_skip <= 1'b0;
    end else if (w_accept) begin
      r_pend_hi   <= w_res_hi;
      r_pend_lo   <= w_res_lo;
      r_pend_skip <= w_div_zero;
    end
  end

  // Divide-by-zero commits nothing; mthi/mtlo only land while idle with no Start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      if (!r_pend_skip) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end else if (w_move_ok) begin
      if (HI_En) r_hi <= A;
      if (LO_En) r_lo <= A;
    end
  end

  assign Busy    = (r_state == S_RUN);
  assign HI      = r_hi;
  assign LO      = r_lo;
  assign MDU_Out = Out_Sel ? r_hi : r_lo;

endmodule
